// File: rtl/prbs_checker_if.sv
// PRBS checker strobe/bit/clear inputs and lock/error status outputs.
// The checker side uses the slave modport; the driver side uses master.
// Pure wiring: no timing or flow control of its own.
interface prbs_checker_if;
    logic       en_i;
    logic       bit_i;
    logic       clear_i;
    logic       locked_o;
    logic       err_o;
    logic [7:0] err_cnt_o;
    logic [1:0] state_o;

    modport master (
        output en_i, bit_i, clear_i,
        input  locked_o, err_o, err_cnt_o, state_o
    );

    modport slave (
        input  en_i, bit_i, clear_i,
        output locked_o, err_o, err_cnt_o, state_o
    );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-8 checker: load, verify, then free-run and count bit errors.
// Latency: every output is registered on the edge that samples the causing strobe.
// No backpressure: the bit is consumed whenever en_i is high; idle cycles hold all state.
module prbs_checker #(
    parameter logic [7:0] TAPS       = 8'hB8,
    parameter int         LOCK_CNT   = 8,
    parameter int         UNLOCK_THR = 4
) (
    input  logic          clk,
    input  logic          reset_ni,
    prbs_checker_if.slave bus
);
    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_THR);

    state_t     state_q;
    logic [7:0] sr_q;
    logic [7:0] sr_d;
    logic [3:0] fill_q;
    logic [3:0] run_q;
    logic [3:0] run_inc;
    logic [7:0] cnt_q;
    logic       err_q;
    logic       pred;
    logic       miss;

    assign pred    = ^(sr_q & TAPS);
    assign miss    = (bus.bit_i != pred);
    assign run_inc = run_q + 4'd1;
    // Once locked the reference free-runs on its own prediction so line errors cannot corrupt it.
    assign sr_d    = (state_q == LOCKED) ? {sr_q[6:0], pred} : {sr_q[6:0], bus.bit_i};

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= LOAD;
            sr_q    <= 8'd0;
            fill_q  <= 4'd0;
            run_q   <= 4'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (bus.en_i) begin
                sr_q <= sr_d;
                case (state_q)
                    LOAD: begin
                        if (fill_q == 4'd7) begin
                            fill_q <= 4'd0;
                            if (sr_d != 8'd0) begin
                                state_q <= VERIFY;
                                run_q   <= 4'd0;
                            end
                        end else begin
                            fill_q <= fill_q + 4'd1;
                        end
                    end
                    VERIFY: begin
                        if (miss) begin
                            state_q <= LOAD;
                            fill_q  <= 4'd0;
                        end else if (run_inc == LOCK_N) begin
                            state_q <= LOCKED;
                            run_q   <= 4'd0;
                        end else begin
                            run_q <= run_inc;
                        end
                    end
                    LOCKED: begin
                        if (miss) begin
                            err_q <= 1'b1;
                            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
                            if (run_inc == UNLOCK_N) begin
                                state_q <= LOAD;
                                fill_q  <= 4'd0;
                                run_q   <= 4'd0;
                            end else begin
                                run_q <= run_inc;
                            end
                        end else begin
                            run_q <= 4'd0;
                        end
                    end
                    default: state_q <= LOAD;
                endcase
            end
            // Clear overrides a same-cycle increment; the error pulse above is unaffected.
            if (bus.clear_i) cnt_q <= 8'd0;
        end
    end

    assign bus.locked_o  = (state_q == LOCKED);
    assign bus.err_o     = err_q;
    assign bus.err_cnt_o = cnt_q;
    assign bus.state_o   = state_q;
endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS-8 checker: the receive end of the 8-bit Fibonacci LFSR sequence generator. It self-synchronises to an incoming bit stream, predicts each next bit with the same polynomial, and declares lock after a run of correct predictions. Once locked it free-runs, flags bit errors and keeps a saturating error count. It sits at the far end of a link or loopback from the LFSR generator and provides the pass/fail status for PRBS tests.

## Interface
- `TAPS`, 8'hB8: feedback mask. Predicted bit = XOR-reduce(`sr & TAPS`), polynomial x^8+x^6+x^5+x^4+1. Must match the generator's feedback.
- `LOCK_CNT`, 8: consecutive correct predictions required in VERIFY before lock (1..15).
- `UNLOCK_THR`, 4: consecutive mismatches in LOCKED that drop lock (1..15).
- `clk` input 1: single clock; everything is rising-edge.
- `reset_ni` input 1: asynchronous, active-low reset.
- `en_i` input 1: bit strobe; `bit_i` is sampled only when high.
- `bit_i` input 1: received serial bit. This is the generator's newly shifted-in feedback bit, its `q[0]` after each step.
- `clear_i` input 1: synchronous clear of `err_cnt_o`.
- `locked_o` output 1: high in the LOCKED state.
- `err_o` output 1: one-cycle pulse on a mismatch while LOCKED.
- `err_cnt_o` output 8: error count, saturates at 255.
- `state_o` output 2: FSM state. LOAD=0, VERIFY=1, LOCKED=2.

## Operation
- Internal state:
  - 8-bit shift register `sr`, shifted left with the new bit entering `sr[0]`, the same as the generator.
  - `pred = ^(sr & TAPS)`.
  - 4-bit fill counter, 4-bit run counter.
- All state changes only on cycles with `en_i`=1, except `clear_i`. When `en_i`=0 everything holds and `err_o`=0.
- **LOAD**:
  - `sr` shifts in `bit_i`; the fill counter increments.
  - On the 8th bit: if the new `sr` is nonzero, go to VERIFY with the run counter at 0.
  - If the new `sr` is all-zero (lock-up state), stay in LOAD and restart the fill counter at 0.
- **VERIFY**:
  - `sr` shifts in `bit_i`.
  - If `bit_i`==`pred`, the run counter increments. When it reaches `LOCK_CNT`, go to LOCKED with the run counter at 0.
  - If `bit_i`!=`pred`, go to LOAD with the fill counter at 0. No error is counted.
- **LOCKED**:
  - `sr` shifts in `pred` (free-run), not `bit_i`, so line errors do not corrupt the reference.
  - Mismatch: `err_o` pulses, `err_cnt_o` increments (saturating), the run counter increments. When it reaches `UNLOCK_THR`, go to LOAD with the fill counter at 0.
  - Match: the run counter resets to 0.
- `err_cnt_o`:
  - Not cleared by loss of lock; only reset or `clear_i` clears it.
  - Holds at 255 on further errors.
  - `clear_i` together with an error: clear wins and the count becomes 0, but `err_o` still pulses.

## Timing
- Reset values: `sr`=0, counters=0, state LOAD, `locked_o`=0, `err_o`=0, `err_cnt_o`=0, `state_o`=0.
- All outputs are registered and change on the clock edge that samples the causing `en_i`/`bit_i`.
- Lock latency from reset with a clean stream: 8 + `LOCK_CNT` strobes. With defaults, `locked_o` rises on the edge of the 16th strobe.
- `err_o` is high for exactly one cycle per erroneous strobe, including back-to-back strobes.
- Unlock: `locked_o` falls on the edge of the `UNLOCK_THR`-th consecutive mismatch. That strobe still pulses `err_o` and still counts.
- `en_i` may be high every cycle or sparse; gaps never change the result.
- Reset assertion mid-operation clears all state immediately (asynchronously). After deassertion the block resumes in LOAD.

## Test plan
- Clean lock:
  - Stimulus: generator seeded 8'h01, stepped every cycle, its `q[0]` driven to `bit_i`.
  - Required: `state_o` goes 0→1 at strobe 8 and 1→2 at strobe 16; `locked_o`=1 thereafter; `err_cnt_o` stays 0 for 1000 strobes.
- Single error:
  - Stimulus: after lock, invert one `bit_i`.
  - Required: one `err_o` pulse, `err_cnt_o`=1, `locked_o` stays 1, and no further errors on the next 300 strobes.
- Loss of lock:
  - Stimulus: after lock, invert 4 consecutive bits.
  - Required: `err_cnt_o`=4, `locked_o` falls on the 4th bad strobe, then relock 16 strobes later with `err_cnt_o` still 4.
- All-zero / VERIFY mismatch:
  - Stimulus: 8 zeros, then a valid stream with one flipped bit during VERIFY.
  - Required: state remains LOAD after the zeros; the flip returns the FSM to LOAD; `err_cnt_o` stays 0.
- Saturation and clear:
  - Stimulus: after lock, drive alternating 3 bad bits and 1 good bit until more than 255 errors.
  - Required: `err_cnt_o`=255 and holding; `clear_i` together with a bad bit gives `err_cnt_o`=0 and `err_o`=1.
- Strobe gaps and reset:
  - Stimulus: random `en_i` duty of 30% on a clean stream; then assert `reset_ni` mid-VERIFY.
  - Required: lock occurs after 16 strobes regardless of gaps; all outputs go to 0 during reset; a full relock follows after release.
